// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Brief    : Game-flow controller for the Space Invaders LCD datapath. It
//            sequences the start, play, wave-pause and game-over phases, and
//            keeps the score and the high score.
//            Optional feature macro: GAME_PAUSE_EN (pause/resume on start press).
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int WAVE_FRAMES = 60,
    parameter int OVER_FRAMES = 120,
    parameter int SCORE_MAX   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_start,
    input  logic [1:0]  plus_score,
    input  logic [2:0]  finished,
    output logic        enable_game,
    output logic        freeze,
    output logic        show_game_start,
    output logic        show_game_over,
    output logic [13:0] score,
    output logic [13:0] high_score,
    output logic [2:0]  game_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_WAVE    = 3'd2;
    localparam logic [2:0] S_RESPAWN = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;
`ifdef GAME_PAUSE_EN
    localparam logic [2:0] S_PAUSED  = 3'd5;
`endif

    localparam logic [7:0]  c_WAVE_TGT  = 8'(WAVE_FRAMES);
    localparam logic [7:0]  c_OVER_TGT  = 8'(OVER_FRAMES);
    localparam logic [14:0] c_SCORE_MAX = 15'(SCORE_MAX);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_btn_d;
    logic        r_entry;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  w_target;
    logic [8:0]  w_cnt_inc;
    logic        w_press;
    logic        w_wave_done;
    logic        w_over_done;
    logic [14:0] w_sum;
    logic [13:0] w_score_sat;
    logic        w_en_next;
    logic        w_fr_next;
    logic        w_ss_next;
    logic        w_so_next;
    logic        r_enable;
    logic        r_freeze;
    logic        r_show_start;
    logic        r_show_over;
    logic [13:0] r_score;
    logic [13:0] r_high_score;

    // Bit 2 of finished carries no meaning for this controller.
    logic w_unused_fin;
    assign w_unused_fin = finished[2];

    assign w_press = btn_start & ~r_btn_d;

    always_comb begin
        w_target = 8'd0;
        case (r_state)
            S_WAVE:  w_target = c_WAVE_TGT;
            S_OVER:  w_target = c_OVER_TGT;
            default: w_target = 8'd0;
        endcase
    end

    assign w_cnt_inc = {1'b0, r_frame_cnt} + 9'd1;

    // Wave exit counts the tick of the current cycle so the state moves one
    // clock after the final tick; game-over only trusts ticks already counted.
    assign w_wave_done = (r_frame_cnt >= c_WAVE_TGT) ||
                         (frame_tick && (w_cnt_inc >= {1'b0, c_WAVE_TGT}));
    assign w_over_done = (r_frame_cnt >= c_OVER_TGT);

    assign w_sum       = {1'b0, r_score} + {13'd0, plus_score};
    assign w_score_sat = (w_sum > c_SCORE_MAX) ? c_SCORE_MAX[13:0] : w_sum[13:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_entry <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_entry <= (w_state_next != r_state);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_press) w_state_next = S_RESPAWN;
            end
            S_RESPAWN: begin
                w_state_next = S_PLAY;
            end
            S_PLAY: begin
                if (finished[1])      w_state_next = S_OVER;
                else if (finished[0]) w_state_next = S_WAVE;
`ifdef GAME_PAUSE_EN
                else if (w_press)     w_state_next = S_PAUSED;
`endif
            end
            S_WAVE: begin
                if (w_wave_done) w_state_next = S_RESPAWN;
            end
            S_OVER: begin
                if (w_press && w_over_done) w_state_next = S_IDLE;
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (w_press) w_state_next = S_PLAY;
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered flags track game_state
    always_comb begin
        w_en_next = 1'b0;
        w_fr_next = 1'b1;
        w_ss_next = 1'b0;
        w_so_next = 1'b0;
        case (w_state_next)
            S_IDLE: begin
                w_ss_next = 1'b1;
            end
            S_RESPAWN: begin
                w_en_next = 1'b0;
            end
            S_PLAY: begin
                w_en_next = 1'b1;
                w_fr_next = 1'b0;
            end
            S_WAVE: begin
                w_en_next = 1'b1;
            end
            S_OVER: begin
                w_en_next = 1'b1;
                w_so_next = 1'b1;
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                w_en_next = 1'b1;
            end
`endif
            default: begin
                w_ss_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable     <= 1'b0;
            r_freeze     <= 1'b1;
            r_show_start <= 1'b1;
            r_show_over  <= 1'b0;
        end else begin
            r_enable     <= w_en_next;
            r_freeze     <= w_fr_next;
            r_show_start <= w_ss_next;
            r_show_over  <= w_so_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_d     <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_btn_d <= btn_start;
            if (w_state_next != r_state) begin
                r_frame_cnt <= 8'd0;
            end else if (frame_tick && (r_frame_cnt < w_target)) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score      <= 14'd0;
            r_high_score <= 14'd0;
        end else begin
            if ((r_state == S_IDLE) && w_press) begin
                r_score <= 14'd0;
            end else if (r_state == S_PLAY) begin
                r_score <= w_score_sat;
            end
            // Latch the best score once, on the first cycle of game-over
            if ((r_state == S_OVER) && r_entry && (r_score > r_high_score)) begin
                r_high_score <= r_score;
            end
        end
    end

    assign enable_game     = r_enable;
    assign freeze          = r_freeze;
    assign show_game_start = r_show_start;
    assign show_game_over  = r_show_over;
    assign score           = r_score;
    assign high_score      = r_high_score;
    assign game_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Brief    : Scoreboard bench for game_sequencer; expected outputs are queued
//            with the cycle they apply to and checked by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        btn_start;
    logic [1:0]  plus_score;
    logic [2:0]  finished;
    logic        enable_game;
    logic        freeze;
    logic        show_game_start;
    logic        show_game_over;
    logic [13:0] score;
    logic [13:0] high_score;
    logic [2:0]  game_state;

    game_sequencer #(
        .WAVE_FRAMES (2),
        .OVER_FRAMES (3),
        .SCORE_MAX   (9999)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .btn_start       (btn_start),
        .plus_score      (plus_score),
        .finished        (finished),
        .enable_game     (enable_game),
        .freeze          (freeze),
        .show_game_start (show_game_start),
        .show_game_over  (show_game_over),
        .score           (score),
        .high_score      (high_score),
        .game_state      (game_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  st;
        logic [13:0] sc;
        logic [13:0] hs;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc++;

    // enable/freeze/start/over for each state code
    function automatic logic [3:0] flags_of(input logic [2:0] st);
        case (st)
            3'd0:    return 4'b0110;
            3'd1:    return 4'b1000;
            3'd2:    return 4'b1100;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1101;
            3'd5:    return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", nm, fld, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            if (m_e.cyc < cyc) begin
                cmp(m_e.name, "stale", cyc, m_e.cyc);
            end else begin
                cmp(m_e.name, "game_state", int'(game_state), int'(m_e.st));
                cmp(m_e.name, "flags", int'({enable_game, freeze, show_game_start, show_game_over}),
                    int'(flags_of(m_e.st)));
                cmp(m_e.name, "score", int'(score), int'(m_e.sc));
                cmp(m_e.name, "high_score", int'(high_score), int'(m_e.hs));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input int sc, input int hs);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.st   = st;
        e.sc   = 14'(sc);
        e.hs   = 14'(hs);
        q.push_back(e);
    endtask

    initial begin
        int es;
        int rem;
        rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b0; plus_score = 2'd0; finished = 3'd0;
        repeat (2) tick();
        chk("reset", 3'd0, 0, 0);
        rst = 1'b0;
        tick(); chk("idle", 3'd0, 0, 0);

        // Start press, held high for two cycles
        btn_start = 1'b1;
        tick(); chk("respawn", 3'd3, 0, 0);
        tick(); chk("play", 3'd1, 0, 0);
        btn_start = 1'b0;

        plus_score = 2'd3;
        tick(); chk("add1", 3'd1, 3, 0);
        tick(); chk("add2", 3'd1, 6, 0);
        tick(); chk("add3", 3'd1, 9, 0);
        tick(); chk("add4", 3'd1, 12, 0);
        plus_score = 2'd2; finished = 3'b011;
        tick(); chk("over_entry", 3'd4, 14, 0);
        plus_score = 2'd0; finished = 3'd0;
        tick(); chk("high_score", 3'd4, 14, 14);

        // Game-over hold-off of three frames
        frame_tick = 1'b1;
        tick(); chk("over_tick1", 3'd4, 14, 14);
        frame_tick = 1'b0; btn_start = 1'b1;
        tick(); chk("over_early_press", 3'd4, 14, 14);
        btn_start = 1'b0; frame_tick = 1'b1;
        tick(); chk("over_tick2", 3'd4, 14, 14);
        btn_start = 1'b1;
        tick(); chk("over_press_with_tick", 3'd4, 14, 14);
        btn_start = 1'b0; frame_tick = 1'b0;
        tick(); chk("over_release", 3'd4, 14, 14);
        btn_start = 1'b1;
        tick(); chk("over_to_idle", 3'd0, 14, 14);
        btn_start = 1'b0;
        tick(); chk("idle_hold", 3'd0, 14, 14);

        btn_start = 1'b1;
        tick(); chk("restart_clear", 3'd3, 0, 14);
        btn_start = 1'b0;
        tick(); chk("play2", 3'd1, 0, 14);

        // Wave cleared, two-frame freeze
        finished = 3'b001; plus_score = 2'd1;
        tick(); chk("wave_entry", 3'd2, 1, 14);
        finished = 3'b010; plus_score = 2'd3;
        tick(); chk("wave_ignore", 3'd2, 1, 14);
        finished = 3'd0; plus_score = 2'd0; frame_tick = 1'b1;
        tick(); chk("wave_tick1", 3'd2, 1, 14);
        tick(); chk("wave_respawn", 3'd3, 1, 14);
        frame_tick = 1'b0;
        tick(); chk("wave_play", 3'd1, 1, 14);
        finished = 3'b100;
        tick(); chk("fin_bit2", 3'd1, 1, 14);
        finished = 3'd0;

        // Start press during play
        btn_start = 1'b1;
`ifdef GAME_PAUSE_EN
        tick(); chk("pause", 3'd5, 1, 14);
        btn_start = 1'b0; plus_score = 2'd3;
        tick(); chk("pause_noscore", 3'd5, 1, 14);
        plus_score = 2'd0; btn_start = 1'b1;
        tick(); chk("resume", 3'd1, 1, 14);
        es = 1;
`else
        tick(); chk("nopause", 3'd1, 1, 14);
        btn_start = 1'b0; plus_score = 2'd3;
        tick(); chk("nopause_score", 3'd1, 4, 14);
        plus_score = 2'd0; btn_start = 1'b1;
        tick(); chk("nopause2", 3'd1, 4, 14);
        es = 4;
`endif
        btn_start = 1'b0;

        // Climb to 9998, then saturate
        plus_score = 2'd3;
        while (es + 3 <= 9998) begin
            tick();
            es += 3;
        end
        rem = 9998 - es;
        if (rem > 0) begin
            plus_score = 2'(rem);
            tick();
            es = 9998;
        end
        plus_score = 2'd0;
        tick(); chk("pre_sat", 3'd1, 9998, 14);
        plus_score = 2'd3;
        tick(); chk("saturate", 3'd1, 9999, 14);
        tick(); chk("sat_hold", 3'd1, 9999, 14);
        plus_score = 2'd0;
        tick();
        rst = 1'b1;
        chk("async_rst", 3'd0, 0, 0);
        tick(); chk("rst_held", 3'd0, 0, 0);
        rst = 1'b0;
        tick(); chk("post_rst", 3'd0, 0, 0);
        tick();
        tick();
        cmp("drain", "queue_left", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
